// File: rtl/svo_text_pkg.sv
// svo_text_pkg: definitions shared by the text writer and its cursor.
//   - control-code constants (CR, LF, BS, FF, ESC, blank glyph)
//   - writer FSM state enum and cursor operation enum
//   - default screen geometry
package svo_text_pkg;

  localparam int COLS_DEFAULT = 64;
  localparam int ROWS_DEFAULT = 19;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2,
    ESC        = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_CR      = 3'd2,
    CUR_BS      = 3'd3,
    CUR_NEWLINE = 3'd4,
    CUR_HOME    = 3'd5
  } cursor_op_t;

endpackage

// File: rtl/svo_text_cursor.sv
// svo_text_cursor: hardware cursor (column/row counters) of the text writer.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   op         : cursor operation applied at the next rising edge
//   col, row   : current cursor position
//   next_row   : row a newline moves to (wraps to 0 after the last row)
module svo_text_cursor
  import svo_text_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  cursor_op_t               op,
  output logic [$clog2(COLS)-1:0]  col,
  output logic [4:0]               row,
  output logic [4:0]               next_row
);

  localparam int              COL_W    = $clog2(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [4:0]       ROW_LAST = 5'(ROWS - 1);

  // Row reached by a newline, wrapping back to the top of the screen.
  always_comb begin
    if (row == ROW_LAST) begin
      next_row = 5'd0;
    end else begin
      next_row = row + 5'd1;
    end
  end

  // Column/row counters; advancing past the last column behaves as a newline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= {COL_W{1'b0}};
      row <= 5'd0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == COL_LAST) begin
            col <= {COL_W{1'b0}};
            row <= next_row;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        CUR_CR: col <= {COL_W{1'b0}};
        CUR_BS: begin
          if (col != {COL_W{1'b0}}) begin
            col <= col - COL_W'(1);
          end else begin
            col <= col;
          end
        end
        CUR_NEWLINE: begin
          col <= {COL_W{1'b0}};
          row <= next_row;
        end
        CUR_HOME: begin
          col <= {COL_W{1'b0}};
          row <= 5'd0;
        end
        default: begin
          col <= col;
          row <= row;
        end
      endcase
    end
  end

endmodule

// File: rtl/svo_text_writer.sv
// svo_text_writer: byte-stream terminal front end driving a text-RAM write port.
// Characters arrive over a valid/ready handshake; CR/LF/BS/FF are interpreted,
// everything else is written at the cursor. LF, line wrap and FF clear RAM by
// sweeping blanks, and the whole screen is swept after reset.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   in_valid/in_ready   : byte handshake, in_data is the byte
//   attr_we/attr_in     : load the current attribute (any state)
//   wen, wdataText, wdataAttr, waddr : registered text-RAM write port
//   cursor_col/cursor_row : cursor position
//   busy                : a clear sweep is in progress
// Build option: define SVO_TEXT_ESC_EN to make 8'h1B a prefix whose following
// byte loads the attribute; otherwise 8'h1B is an ordinary glyph.
module svo_text_writer
  import svo_text_pkg::*;
#(
  parameter int         COLS         = COLS_DEFAULT,
  parameter int         ROWS         = ROWS_DEFAULT,
  parameter int         ADDR_W       = 11,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    attr_we,
  input  logic [7:0]              attr_in,
  output logic                    wen,
  output logic [7:0]              wdataText,
  output logic [7:0]              wdataAttr,
  output logic [ADDR_W-1:0]       waddr,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [4:0]              cursor_row,
  output logic                    busy
);

  localparam int                COL_W       = $clog2(COLS);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(ROWS * COLS - 1);

  state_t            state_r, state_s;
  cursor_op_t        cur_op_s;
  logic [4:0]        next_row_s;
  logic [4:0]        line_row_r;
  logic [ADDR_W-1:0] cnt_r, sweep_last_s, sweep_addr_s, cell_addr_s;
  logic              done_r;
  logic [7:0]        attr_r, eff_attr_s;
  logic              accept_s, esc_load_s;
  logic              wen_s;
  logic [7:0]        text_s, wattr_s;
  logic [ADDR_W-1:0] addr_s;

  // Bytes that land in text RAM as glyphs rather than being interpreted.
  function automatic logic is_glyph(input logic [7:0] b);
    case (b)
      CH_CR, CH_LF, CH_BS, CH_FF: is_glyph = 1'b0;
`ifdef SVO_TEXT_ESC_EN
      CH_ESC:                     is_glyph = 1'b0;
`endif
      default:                    is_glyph = 1'b1;
    endcase
  endfunction

  svo_text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .op       (cur_op_s),
    .col      (cursor_col),
    .row      (cursor_row),
    .next_row (next_row_s)
  );

  assign accept_s    = in_valid && in_ready;
  // An attribute load on the same edge as a printable colours that printable.
  assign eff_attr_s  = attr_we ? attr_in : attr_r;
  assign cell_addr_s = (ADDR_W'(cursor_row) << COL_W) | ADDR_W'(cursor_col);
`ifdef SVO_TEXT_ESC_EN
  assign esc_load_s  = (state_r == ESC) && accept_s;
`else
  assign esc_load_s  = 1'b0;
`endif

  // Sweep terminal count and address for the active clear.
  always_comb begin
    if (state_r == CLR_LINE) begin
      sweep_last_s = LINE_LAST;
      sweep_addr_s = (ADDR_W'(line_row_r) << COL_W) | cnt_r;
    end else begin
      sweep_last_s = SCREEN_LAST;
      sweep_addr_s = cnt_r;
    end
  end

  // FSM state register; reset lands in CLR_SCREEN so the screen self-clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= CLR_SCREEN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and cursor-operation decode.
  always_comb begin
    state_s  = state_r;
    cur_op_s = CUR_HOLD;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (in_data)
            CH_CR: cur_op_s = CUR_CR;
            CH_LF: begin
              cur_op_s = CUR_NEWLINE;
              state_s  = CLR_LINE;
            end
            CH_BS: cur_op_s = CUR_BS;
            CH_FF: begin
              cur_op_s = CUR_HOME;
              state_s  = CLR_SCREEN;
            end
`ifdef SVO_TEXT_ESC_EN
            CH_ESC: state_s = ESC;
`endif
            default: begin
              cur_op_s = CUR_ADVANCE;
              if (cursor_col == COL_LAST) begin
                state_s = CLR_LINE;
              end else begin
                state_s = IDLE;
              end
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      // One trailing cycle after the last write so in_ready rises after it.
      CLR_LINE, CLR_SCREEN: begin
        if (done_r) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ESC: begin
        if (accept_s) begin
          state_s = IDLE;
        end else begin
          state_s = ESC;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: printable write in IDLE, blank write on each sweep step.
  always_comb begin
    wen_s   = 1'b0;
    text_s  = wdataText;
    wattr_s = wdataAttr;
    addr_s  = waddr;
    case (state_r)
      IDLE: begin
        if (accept_s && is_glyph(in_data)) begin
          wen_s   = 1'b1;
          text_s  = in_data;
          wattr_s = eff_attr_s;
          addr_s  = cell_addr_s;
        end else begin
          wen_s = 1'b0;
        end
      end
      CLR_LINE, CLR_SCREEN: begin
        if (!done_r) begin
          wen_s   = 1'b1;
          text_s  = CH_BLANK;
          wattr_s = eff_attr_s;
          addr_s  = sweep_addr_s;
        end else begin
          wen_s = 1'b0;
        end
      end
      default: wen_s = 1'b0;
    endcase
  end

  // Sweep counter; outside sweeps it stays cleared and tracks the newline row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= {ADDR_W{1'b0}};
      done_r     <= 1'b0;
      line_row_r <= 5'd0;
    end else begin
      case (state_r)
        CLR_LINE, CLR_SCREEN: begin
          if (!done_r) begin
            if (cnt_r == sweep_last_s) begin
              done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + ADDR_W'(1);
            end
          end
        end
        default: begin
          cnt_r      <= {ADDR_W{1'b0}};
          done_r     <= 1'b0;
          line_row_r <= next_row_s;
        end
      endcase
    end
  end

  // Current attribute; the byte after ESC takes priority over attr_we.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attr_r <= DEFAULT_ATTR;
    end else if (esc_load_s) begin
      attr_r <= in_data;
    end else if (attr_we) begin
      attr_r <= attr_in;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen       <= 1'b0;
      wdataText <= 8'h00;
      wdataAttr <= 8'h00;
      waddr     <= {ADDR_W{1'b0}};
      in_ready  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      wen       <= wen_s;
      wdataText <= text_s;
      wdataAttr <= wattr_s;
      waddr     <= addr_s;
      in_ready  <= (state_s == IDLE) || (state_s == ESC);
      busy      <= (state_s == CLR_LINE) || (state_s == CLR_SCREEN);
    end
  end

endmodule
